// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg
//   Shared definitions for the main-memory port arbiter: FSM state enum,
//   requester class IDs, grant bit positions, default widths and the
//   response timeout default.
package mem_port_arbiter_pkg;

   localparam int DATA_W_DEF      = 32;
   localparam int ADDR_W_DEF      = 32;
   localparam int LINE_WORDS_DEF  = 4;
   localparam int TIMEOUT_CYC_DEF = 255;
   localparam int CNT_W           = 8;   // timeout counter width

   // Bit positions inside the one-hot grant vector of mem_arb_rr2
   localparam int GNT_I = 0;
   localparam int GNT_D = 1;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_IC_RD = 3'd1,
      ST_DC_RD = 3'd2,
      ST_DC_WR = 3'd3,
      ST_RESP  = 3'd4
   } arb_state_e;

   typedef enum logic {
      CLS_I = 1'b0,
      CLS_D = 1'b1
   } arb_cls_e;

   // True for the two states that wait on a memory line read
   function automatic logic is_rd_state(arb_state_e st);
      return (st == ST_IC_RD) || (st == ST_DC_RD);
   endfunction

endpackage

// File: rtl/mem_arb_rr2.sv
// mem_arb_rr2
//   Two-input round-robin picker.  The pointer holds the class granted last;
//   under contention the other class wins.  A lone request always wins.
//   Ports:
//     req_i    in   I-class request
//     req_d    in   D-class request
//     ptr      in   class granted last
//     grant    out  one-hot grant (bit GNT_I / GNT_D), zero when idle
//     ptr_next out  pointer value to store if the grant is taken
module mem_arb_rr2
   import mem_port_arbiter_pkg::*;
(
   input  logic       req_i,
   input  logic       req_d,
   input  arb_cls_e   ptr,
   output logic [1:0] grant,
   output arb_cls_e   ptr_next
);

   always_comb begin
      grant    = 2'b00;
      ptr_next = ptr;
      if (req_i && req_d) begin
         if (ptr == CLS_D) grant[GNT_I] = 1'b1;
         else              grant[GNT_D] = 1'b1;
      end else if (req_i) begin
         grant[GNT_I] = 1'b1;
      end else if (req_d) begin
         grant[GNT_D] = 1'b1;
      end

      if (grant[GNT_D])      ptr_next = CLS_D;
      else if (grant[GNT_I]) ptr_next = CLS_I;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single main-memory port between the I-cache (line fills) and
//   the D-cache (line fills and write-through stores).  One transaction is
//   outstanding at a time, the two cache classes are served round-robin, and
//   a memory response that never arrives is cut off after TIMEOUT_CYC cycles.
//   Every output is a flop.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     ic_rd_req/ic_rd_addr           I-cache fill request (level, held)
//     ic_rd_valid/ic_rd_line         I-cache fill-complete pulse + line
//     dc_rd_req/dc_wr_req/dc_addr    D-cache fill / store request (level)
//     dc_wr_data/dc_wr_byte/hword    D-cache store data and size
//     dc_rd_valid/dc_rd_line         D-cache fill-complete pulse + line
//     dc_wr_done                     D-cache store-complete pulse
//     mem_rd_en/mem_wr_en            memory strobes
//     mem_addr/mem_wr_data/size      registered memory request fields
//     mem_rd_valid/mem_rd_line       memory line-read response
//     mem_wr_ready                   memory write accept
//     timeout_err                    sticky timeout flag
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_W      = DATA_W_DEF,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int LINE_WORDS  = LINE_WORDS_DEF,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                         clk,
   input  logic                         rst_n,

   input  logic                         ic_rd_req,
   input  logic [ADDR_W-1:0]            ic_rd_addr,
   output logic                         ic_rd_valid,
   output logic [DATA_W*LINE_WORDS-1:0] ic_rd_line,

   input  logic                         dc_rd_req,
   input  logic                         dc_wr_req,
   input  logic [ADDR_W-1:0]            dc_addr,
   input  logic [DATA_W-1:0]            dc_wr_data,
   input  logic                         dc_wr_byte,
   input  logic                         dc_wr_hword,
   output logic                         dc_rd_valid,
   output logic [DATA_W*LINE_WORDS-1:0] dc_rd_line,
   output logic                         dc_wr_done,

   output logic                         mem_rd_en,
   output logic                         mem_wr_en,
   output logic [ADDR_W-1:0]            mem_addr,
   output logic [DATA_W-1:0]            mem_wr_data,
   output logic                         mem_wr_byte,
   output logic                         mem_wr_hword,
   input  logic                         mem_rd_valid,
   input  logic [DATA_W*LINE_WORDS-1:0] mem_rd_line,
   input  logic                         mem_wr_ready,

   output logic                         timeout_err
);

   arb_state_e       state_reg;
   arb_cls_e         rr_ptr_reg;
   arb_cls_e         rr_ptr_next;
   logic [CNT_W-1:0] cnt_reg;
   logic [1:0]       grant;
   logic             rsp_hit;
   logic             tmo_hit;

   // Store wins over fill inside the D class, so the class request is the OR
   mem_arb_rr2 u_rr (
      .req_i    (ic_rd_req),
      .req_d    (dc_rd_req | dc_wr_req),
      .ptr      (rr_ptr_reg),
      .grant    (grant),
      .ptr_next (rr_ptr_next)
   );

   // Only the response that matches the outstanding operation counts
   always_comb begin
      rsp_hit = 1'b0;
      if (is_rd_state(state_reg))    rsp_hit = mem_rd_valid;
      else if (state_reg == ST_DC_WR) rsp_hit = mem_wr_ready;
      // Counter starts at 0 in the first strobe cycle, so TIMEOUT_CYC-1 marks
      // the last cycle the strobe may stay high
      tmo_hit = (cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= ST_IDLE;
         rr_ptr_reg   <= CLS_I;          // first contention goes to D
         cnt_reg      <= '0;
         mem_rd_en    <= 1'b0;
         mem_wr_en    <= 1'b0;
         mem_addr     <= '0;
         mem_wr_data  <= '0;
         mem_wr_byte  <= 1'b0;
         mem_wr_hword <= 1'b0;
         ic_rd_valid  <= 1'b0;
         dc_rd_valid  <= 1'b0;
         dc_wr_done   <= 1'b0;
         ic_rd_line   <= '0;
         dc_rd_line   <= '0;
         timeout_err  <= 1'b0;
      end else begin
         // Completion pulses last exactly one cycle (the RESP cycle)
         ic_rd_valid <= 1'b0;
         dc_rd_valid <= 1'b0;
         dc_wr_done  <= 1'b0;

         unique case (state_reg)
            ST_IDLE: begin
               if (grant != 2'b00) begin
                  rr_ptr_reg <= rr_ptr_next;
                  cnt_reg    <= '0;
                  if (grant[GNT_I]) begin
                     state_reg <= ST_IC_RD;
                     mem_rd_en <= 1'b1;
                     mem_addr  <= ic_rd_addr;
                  end else if (dc_wr_req) begin
                     state_reg    <= ST_DC_WR;
                     mem_wr_en    <= 1'b1;
                     mem_addr     <= dc_addr;
                     mem_wr_data  <= dc_wr_data;
                     mem_wr_byte  <= dc_wr_byte;
                     mem_wr_hword <= dc_wr_hword;
                  end else begin
                     state_reg <= ST_DC_RD;
                     mem_rd_en <= 1'b1;
                     mem_addr  <= dc_addr;
                  end
               end
            end

            ST_IC_RD, ST_DC_RD, ST_DC_WR: begin
               cnt_reg <= cnt_reg + CNT_W'(1);
               if (rsp_hit || tmo_hit) begin
                  state_reg <= ST_RESP;
                  mem_rd_en <= 1'b0;
                  mem_wr_en <= 1'b0;
                  if (!rsp_hit) timeout_err <= 1'b1;
                  // A timed-out fill returns an all-zero line
                  case (state_reg)
                     ST_IC_RD: begin
                        ic_rd_valid <= 1'b1;
                        ic_rd_line  <= rsp_hit ? mem_rd_line : '0;
                     end
                     ST_DC_RD: begin
                        dc_rd_valid <= 1'b1;
                        dc_rd_line  <= rsp_hit ? mem_rd_line : '0;
                     end
                     default: dc_wr_done <= 1'b1;
                  endcase
               end
            end

            ST_RESP: state_reg <= ST_IDLE;

            default: state_reg <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   localparam int DATA_W      = 32;
   localparam int ADDR_W      = 32;
   localparam int LINE_WORDS  = 4;
   localparam int TIMEOUT_CYC = 255;
   localparam int LINE_W      = DATA_W * LINE_WORDS;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              ic_rd_req = 1'b0;
   logic [ADDR_W-1:0] ic_rd_addr = '0;
   logic              ic_rd_valid;
   logic [LINE_W-1:0] ic_rd_line;
   logic              dc_rd_req = 1'b0;
   logic              dc_wr_req = 1'b0;
   logic [ADDR_W-1:0] dc_addr = '0;
   logic [DATA_W-1:0] dc_wr_data = '0;
   logic              dc_wr_byte = 1'b0;
   logic              dc_wr_hword = 1'b0;
   logic              dc_rd_valid;
   logic [LINE_W-1:0] dc_rd_line;
   logic              dc_wr_done;
   logic              mem_rd_en;
   logic              mem_wr_en;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wr_data;
   logic              mem_wr_byte;
   logic              mem_wr_hword;
   logic              mem_rd_valid = 1'b0;
   logic [LINE_W-1:0] mem_rd_line = '0;
   logic              mem_wr_ready = 1'b0;
   logic              timeout_err;

   mem_port_arbiter #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .LINE_WORDS(LINE_WORDS), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .ic_rd_req(ic_rd_req), .ic_rd_addr(ic_rd_addr),
      .ic_rd_valid(ic_rd_valid), .ic_rd_line(ic_rd_line),
      .dc_rd_req(dc_rd_req), .dc_wr_req(dc_wr_req), .dc_addr(dc_addr),
      .dc_wr_data(dc_wr_data), .dc_wr_byte(dc_wr_byte), .dc_wr_hword(dc_wr_hword),
      .dc_rd_valid(dc_rd_valid), .dc_rd_line(dc_rd_line), .dc_wr_done(dc_wr_done),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_wr_byte(mem_wr_byte), .mem_wr_hword(mem_wr_hword),
      .mem_rd_valid(mem_rd_valid), .mem_rd_line(mem_rd_line), .mem_wr_ready(mem_wr_ready),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int ic_pulses  = 0;
   int dcr_pulses = 0;
   int dcw_pulses = 0;
   bit model_last_d = 1'b0;   // reference round-robin state: 1 = D granted last

   // Pulse tally, sampled mid-cycle
   always @(negedge clk) begin
      if (ic_rd_valid === 1'b1) ic_pulses++;
      if (dc_rd_valid === 1'b1) dcr_pulses++;
      if (dc_wr_done === 1'b1)  dcw_pulses++;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout, want finish");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      ic_rd_req = 1'b0; dc_rd_req = 1'b0; dc_wr_req = 1'b0;
      dc_wr_byte = 1'b0; dc_wr_hword = 1'b0;
      mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
   endtask

   task automatic apply_reset();
      idle_inputs();
      rst_n = 1'b0;
      tick(); tick();
      rst_n = 1'b1;
      model_last_d = 1'b0;
      tick();
   endtask

   function automatic logic [LINE_W-1:0] rand_line();
      logic [LINE_W-1:0] l;
      for (int w = 0; w < LINE_WORDS; w++) l[w*DATA_W +: DATA_W] = $urandom;
      return l;
   endfunction

   task automatic test_reset();
      idle_inputs();
      rst_n = 1'b0;
      ic_rd_req = 1'b1; dc_wr_req = 1'b1; dc_addr = 32'h1234; dc_wr_data = 32'h5555_AAAA;
      tick(); tick();
      n_checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {mem_rd_en, mem_wr_en}); else n_pass++;
      n_checks++; if (mem_addr !== '0) $display("FAIL rst_addr: got %h want 0", mem_addr); else n_pass++;
      n_checks++; if (mem_wr_data !== '0) $display("FAIL rst_wdata: got %h want 0", mem_wr_data); else n_pass++;
      n_checks++; if ({mem_wr_byte, mem_wr_hword} !== 2'b00) $display("FAIL rst_size: got %b want 00", {mem_wr_byte, mem_wr_hword}); else n_pass++;
      n_checks++; if ({ic_rd_valid, dc_rd_valid, dc_wr_done} !== 3'b000) $display("FAIL rst_pulses: got %b want 000", {ic_rd_valid, dc_rd_valid, dc_wr_done}); else n_pass++;
      n_checks++; if (ic_rd_line !== '0) $display("FAIL rst_ic_line: got %h want 0", ic_rd_line); else n_pass++;
      n_checks++; if (dc_rd_line !== '0) $display("FAIL rst_dc_line: got %h want 0", dc_rd_line); else n_pass++;
      n_checks++; if (timeout_err !== 1'b0) $display("FAIL rst_timeout_err: got %b want 0", timeout_err); else n_pass++;
      idle_inputs();
      rst_n = 1'b1;
      model_last_d = 1'b0;
      tick();
      n_checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) $display("FAIL rst_release_idle: got %b want 00", {mem_rd_en, mem_wr_en}); else n_pass++;
   endtask

   task automatic test_ic_fill();
      logic [LINE_W-1:0] line;
      line = {32'h0000_000D, 32'h0000_000C, 32'h0000_000B, 32'h0000_000A};
      ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_1000;        // cycle 0
      tick();                                                // cycle 1
      n_checks++; if (mem_rd_en !== 1'b1) $display("FAIL fill_strobe_c1: got %b want 1", mem_rd_en); else n_pass++;
      n_checks++; if (mem_addr !== 32'h0000_1000) $display("FAIL fill_addr: got %h want 00001000", mem_addr); else n_pass++;
      for (int c = 2; c <= 4; c++) begin
         tick();
         n_checks++; if (mem_rd_en !== 1'b1) $display("FAIL fill_strobe_c%0d: got %b want 1", c, mem_rd_en); else n_pass++;
      end
      mem_rd_valid = 1'b1; mem_rd_line = line;               // sampled end of cycle 4
      tick();                                                // cycle 5
      mem_rd_valid = 1'b0;
      n_checks++; if (ic_rd_valid !== 1'b1) $display("FAIL fill_pulse_c5: got %b want 1", ic_rd_valid); else n_pass++;
      n_checks++; if (ic_rd_line !== line) $display("FAIL fill_line: got %h want %h", ic_rd_line, line); else n_pass++;
      n_checks++; if ({mem_rd_en, dc_rd_valid, dc_wr_done} !== 3'b000) $display("FAIL fill_c5_others: got %b want 000", {mem_rd_en, dc_rd_valid, dc_wr_done}); else n_pass++;
      ic_rd_req = 1'b0;
      model_last_d = 1'b0;
      tick();                                                // cycle 6 IDLE
      n_checks++; if ({ic_rd_valid, mem_rd_en} !== 2'b00) $display("FAIL fill_c6_idle: got %b want 00", {ic_rd_valid, mem_rd_en}); else n_pass++;
   endtask

   // Pair, lone D fill, pair: the two pairs resolve in opposite orders
   task automatic test_contention();
      logic [ADDR_W-1:0] a_i, a_d;
      logic [LINE_W-1:0] line;
      bit pend_i, pend_d, exp_d;
      apply_reset();
      for (int s = 0; s < 3; s++) begin
         pend_i = (s != 1); pend_d = 1'b1;
         a_i = 32'h0000_2000 + 32'(s * 64); a_d = 32'h0000_3000 + 32'(s * 64);
         ic_rd_req = pend_i; ic_rd_addr = a_i; dc_rd_req = 1'b1; dc_addr = a_d;
         for (int k = 0; k < 2 && (pend_i || pend_d); k++) begin
            if (k == 0) tick(); else begin tick(); tick(); end
            exp_d = (pend_i && pend_d) ? !model_last_d : pend_d;
            model_last_d = exp_d;
            n_checks++; if (mem_rd_en !== 1'b1) $display("FAIL cont_s%0d_k%0d_strobe: got %b want 1", s, k, mem_rd_en); else n_pass++;
            n_checks++; if (mem_addr !== (exp_d ? a_d : a_i)) $display("FAIL cont_s%0d_k%0d_addr: got %h want %h", s, k, mem_addr, exp_d ? a_d : a_i); else n_pass++;
            line = rand_line();
            mem_rd_valid = 1'b1; mem_rd_line = line;
            tick();
            mem_rd_valid = 1'b0;
            n_checks++; if ({ic_rd_valid, dc_rd_valid} !== (exp_d ? 2'b01 : 2'b10)) $display("FAIL cont_s%0d_k%0d_pulse: got %b want %b", s, k, {ic_rd_valid, dc_rd_valid}, exp_d ? 2'b01 : 2'b10); else n_pass++;
            if (exp_d) begin dc_rd_req = 1'b0; pend_d = 1'b0; end
            else begin ic_rd_req = 1'b0; pend_i = 1'b0; end
         end
         tick();
      end
   endtask

   task automatic test_write_priority();
      logic [LINE_W-1:0] line;
      int w0;
      w0 = dcw_pulses;
      dc_wr_req = 1'b1; dc_rd_req = 1'b1; dc_addr = 32'h0000_0040;
      dc_wr_data = 32'hDEAD_BEEF; dc_wr_byte = 1'b1; dc_wr_hword = 1'b0;
      tick();                                                // c1
      n_checks++; if ({mem_wr_en, mem_rd_en} !== 2'b10) $display("FAIL wr_strobe: got %b want 10", {mem_wr_en, mem_rd_en}); else n_pass++;
      n_checks++; if (mem_addr !== 32'h0000_0040) $display("FAIL wr_addr: got %h want 00000040", mem_addr); else n_pass++;
      n_checks++; if (mem_wr_data !== 32'hDEAD_BEEF) $display("FAIL wr_data: got %h want deadbeef", mem_wr_data); else n_pass++;
      n_checks++; if ({mem_wr_byte, mem_wr_hword} !== 2'b10) $display("FAIL wr_size: got %b want 10", {mem_wr_byte, mem_wr_hword}); else n_pass++;
      mem_rd_valid = 1'b1;                                   // wrong response kind
      tick();                                                // c2
      mem_rd_valid = 1'b0;
      n_checks++; if (mem_wr_en !== 1'b1) $display("FAIL wr_ignores_rd_valid: got %b want 1", mem_wr_en); else n_pass++;
      mem_wr_ready = 1'b1;
      tick();                                                // c3
      mem_wr_ready = 1'b0;
      n_checks++; if ({dc_wr_done, dc_rd_valid, mem_wr_en} !== 3'b100) $display("FAIL wr_done_pulse: got %b want 100", {dc_wr_done, dc_rd_valid, mem_wr_en}); else n_pass++;
      dc_wr_req = 1'b0; dc_wr_byte = 1'b0; dc_addr = 32'h0000_0080;
      tick();                                                // c4 IDLE
      n_checks++; if (dc_wr_done !== 1'b0) $display("FAIL wr_done_single: got %b want 0", dc_wr_done); else n_pass++;
      tick();                                                // c5
      n_checks++; if ({mem_rd_en, mem_addr} !== {1'b1, 32'h0000_0080}) $display("FAIL wr_then_rd: got %b/%h want 1/00000080", mem_rd_en, mem_addr); else n_pass++;
      line = rand_line();
      mem_rd_valid = 1'b1; mem_rd_line = line;
      tick();                                                // c6
      mem_rd_valid = 1'b0;
      n_checks++; if (dc_rd_valid !== 1'b1 || dc_rd_line !== line) $display("FAIL wr_then_rd_line: got %b/%h want 1/%h", dc_rd_valid, dc_rd_line, line); else n_pass++;
      n_checks++; if (dcw_pulses - w0 !== 1) $display("FAIL wr_done_count: got %0d want 1", dcw_pulses - w0); else n_pass++;
      dc_rd_req = 1'b0;
      model_last_d = 1'b1;
      tick();
   endtask

   // Req held through the cycle after its pulse starts a second fill; that
   // second req is then withdrawn mid-transaction and must still complete.
   task automatic test_back_to_back();
      logic [LINE_W-1:0] l1, l2;
      int ic0;
      ic0 = ic_pulses;
      l1 = rand_line(); l2 = rand_line();
      ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_6000;
      tick();                                                // c1
      n_checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0000_6000) $display("FAIL b2b_first: got %b/%h want 1/00006000", mem_rd_en, mem_addr); else n_pass++;
      mem_rd_valid = 1'b1; mem_rd_line = l1;
      tick();                                                // c2
      mem_rd_valid = 1'b0;
      n_checks++; if (ic_rd_valid !== 1'b1 || ic_rd_line !== l1) $display("FAIL b2b_pulse1: got %b/%h want 1/%h", ic_rd_valid, ic_rd_line, l1); else n_pass++;
      ic_rd_addr = 32'h0000_6100;
      tick();                                                // c3 IDLE, req still high
      n_checks++; if ({ic_rd_valid, mem_rd_en} !== 2'b00) $display("FAIL b2b_idle: got %b want 00", {ic_rd_valid, mem_rd_en}); else n_pass++;
      tick();                                                // c4
      n_checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0000_6100) $display("FAIL b2b_second: got %b/%h want 1/00006100", mem_rd_en, mem_addr); else n_pass++;
      ic_rd_req = 1'b0;
      tick();                                                // c5
      n_checks++; if (mem_rd_en !== 1'b1) $display("FAIL b2b_withdrawn_hold: got %b want 1", mem_rd_en); else n_pass++;
      mem_rd_valid = 1'b1; mem_rd_line = l2;
      tick();                                                // c6
      mem_rd_valid = 1'b0;
      n_checks++; if (ic_rd_valid !== 1'b1 || ic_rd_line !== l2) $display("FAIL b2b_pulse2: got %b/%h want 1/%h", ic_rd_valid, ic_rd_line, l2); else n_pass++;
      tick(); tick(); tick();
      n_checks++; if (ic_pulses - ic0 !== 2) $display("FAIL b2b_pulse_count: got %0d want 2", ic_pulses - ic0); else n_pass++;
      n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL b2b_quiet: got %b want 0", mem_rd_en); else n_pass++;
      model_last_d = 1'b0;
   endtask

   // Random request mixes against a transaction-order model
   task automatic test_random();
      int ops[$];
      bit want_i, want_dr, want_dw, pend_i, pend_dr, pend_dw, pick_d;
      logic [ADDR_W-1:0] a_i, a_dr, a_dw, exp_addr;
      logic [DATA_W-1:0] wdata;
      logic [LINE_W-1:0] line;
      int sz, lat, op;
      for (int r = 0; r < 25; r++) begin
         do begin
            want_i = 1'($urandom); want_dr = 1'($urandom); want_dw = 1'($urandom);
         end while (!(want_i || want_dr || want_dw));
         a_i = $urandom; a_dr = $urandom; a_dw = $urandom; wdata = $urandom;
         sz = $urandom_range(0, 2);
         ops.delete();
         pend_i = want_i; pend_dr = want_dr; pend_dw = want_dw;
         while (pend_i || pend_dr || pend_dw) begin
            if (pend_i && (pend_dr || pend_dw)) pick_d = !model_last_d;
            else                                pick_d = !pend_i;
            if (!pick_d)      begin ops.push_back(0); pend_i  = 1'b0; end
            else if (pend_dw) begin ops.push_back(2); pend_dw = 1'b0; end
            else              begin ops.push_back(1); pend_dr = 1'b0; end
            model_last_d = pick_d;
         end
         ic_rd_req = want_i; ic_rd_addr = a_i;
         dc_rd_req = want_dr; dc_wr_req = want_dw;
         dc_addr = want_dw ? a_dw : a_dr;
         dc_wr_data = wdata; dc_wr_byte = (sz == 1); dc_wr_hword = (sz == 2);
         for (int k = 0; k < ops.size(); k++) begin
            op = ops[k];
            if (k == 0) tick(); else begin tick(); tick(); end
            exp_addr = (op == 0) ? a_i : (op == 1) ? a_dr : a_dw;
            n_checks++; if ({mem_rd_en, mem_wr_en} !== ((op == 2) ? 2'b01 : 2'b10)) $display("FAIL rnd_r%0d_k%0d_strobe: got %b want %b", r, k, {mem_rd_en, mem_wr_en}, (op == 2) ? 2'b01 : 2'b10); else n_pass++;
            n_checks++; if (mem_addr !== exp_addr) $display("FAIL rnd_r%0d_k%0d_addr: got %h want %h", r, k, mem_addr, exp_addr); else n_pass++;
            if (op == 2) begin
               n_checks++; if ({mem_wr_data, mem_wr_byte, mem_wr_hword} !== {wdata, sz == 1, sz == 2}) $display("FAIL rnd_r%0d_k%0d_wfields: got %h/%b%b want %h/%b%b", r, k, mem_wr_data, mem_wr_byte, mem_wr_hword, wdata, sz == 1, sz == 2); else n_pass++;
            end
            lat = $urandom_range(1, 4);
            line = rand_line();
            mem_rd_line = line;
            for (int j = 0; j < lat; j++) begin
               if (j > 0) begin
                  n_checks++; if ((mem_rd_en | mem_wr_en) !== 1'b1 || mem_addr !== exp_addr) $display("FAIL rnd_r%0d_k%0d_hold%0d: got %b/%h want 1/%h", r, k, j, mem_rd_en | mem_wr_en, mem_addr, exp_addr); else n_pass++;
               end
               if (op == 2) begin
                  mem_wr_ready = (j == lat - 1);
                  mem_rd_valid = 1'($urandom);            // must be ignored
               end else begin
                  mem_rd_valid = (j == lat - 1);
                  mem_wr_ready = 1'($urandom);            // must be ignored
               end
               tick();
            end
            mem_rd_valid = 1'b0; mem_wr_ready = 1'b0;
            n_checks++; if ({ic_rd_valid, dc_rd_valid, dc_wr_done} !== ((op == 0) ? 3'b100 : (op == 1) ? 3'b010 : 3'b001)) $display("FAIL rnd_r%0d_k%0d_pulse: got %b want op %0d", r, k, {ic_rd_valid, dc_rd_valid, dc_wr_done}, op); else n_pass++;
            n_checks++; if ((mem_rd_en | mem_wr_en) !== 1'b0) $display("FAIL rnd_r%0d_k%0d_drop: got %b want 0", r, k, mem_rd_en | mem_wr_en); else n_pass++;
            if (op == 0) begin
               n_checks++; if (ic_rd_line !== line) $display("FAIL rnd_r%0d_k%0d_icline: got %h want %h", r, k, ic_rd_line, line); else n_pass++;
               ic_rd_req = 1'b0;
            end else if (op == 1) begin
               n_checks++; if (dc_rd_line !== line) $display("FAIL rnd_r%0d_k%0d_dcline: got %h want %h", r, k, dc_rd_line, line); else n_pass++;
               dc_rd_req = 1'b0;
            end else begin
               dc_wr_req = 1'b0; dc_addr = a_dr;
            end
         end
         tick();
         n_checks++; if ({mem_rd_en, mem_wr_en} !== 2'b00) $display("FAIL rnd_r%0d_idle: got %b want 00", r, {mem_rd_en, mem_wr_en}); else n_pass++;
         repeat ($urandom_range(0, 2)) tick();
      end
   endtask

   task automatic test_timeout();
      int held, d0;
      d0 = dcr_pulses;
      dc_rd_req = 1'b1; dc_addr = 32'h0000_0300;
      mem_rd_line = {LINE_WORDS{32'hFFFF_0000}};           // junk that must not be captured
      tick();                                                // c1
      n_checks++; if (mem_rd_en !== 1'b1) $display("FAIL tmo_strobe: got %b want 1", mem_rd_en); else n_pass++;
      held = 0;
      while (mem_rd_en === 1'b1 && held < TIMEOUT_CYC + 20) begin
         held++;
         mem_wr_ready = (held == 100);                      // wrong response kind
         tick();
      end
      mem_wr_ready = 1'b0;
      n_checks++; if (held !== TIMEOUT_CYC) $display("FAIL tmo_strobe_cycles: got %0d want %0d", held, TIMEOUT_CYC); else n_pass++;
      n_checks++; if (dc_rd_valid !== 1'b1) $display("FAIL tmo_pulse: got %b want 1", dc_rd_valid); else n_pass++;
      n_checks++; if (dc_rd_line !== '0) $display("FAIL tmo_line: got %h want 0", dc_rd_line); else n_pass++;
      n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo_err_set: got %b want 1", timeout_err); else n_pass++;
      dc_rd_req = 1'b0;
      model_last_d = 1'b1;
      tick(); tick(); tick();
      n_checks++; if (timeout_err !== 1'b1) $display("FAIL tmo_err_sticky: got %b want 1", timeout_err); else n_pass++;
      n_checks++; if (dcr_pulses - d0 !== 1) $display("FAIL tmo_pulse_count: got %0d want 1", dcr_pulses - d0); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [LINE_W-1:0] line;
      int ic0;
      ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_5000;
      tick(); tick();
      n_checks++; if (mem_rd_en !== 1'b1) $display("FAIL rmid_pre: got %b want 1", mem_rd_en); else n_pass++;
      ic0 = ic_pulses;
      rst_n = 1'b0;
      #1;
      n_checks++; if ({mem_rd_en, mem_wr_en, ic_rd_valid} !== 3'b000) $display("FAIL rmid_async_strobe: got %b want 000", {mem_rd_en, mem_wr_en, ic_rd_valid}); else n_pass++;
      n_checks++; if (mem_addr !== '0 || timeout_err !== 1'b0) $display("FAIL rmid_async_regs: got %h/%b want 0/0", mem_addr, timeout_err); else n_pass++;
      mem_rd_valid = 1'b1;
      tick();
      ic_rd_req = 1'b0; mem_rd_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      model_last_d = 1'b0;
      tick(); tick(); tick();
      n_checks++; if (ic_pulses !== ic0) $display("FAIL rmid_no_pulse: got %0d want %0d", ic_pulses, ic0); else n_pass++;
      n_checks++; if (mem_rd_en !== 1'b0) $display("FAIL rmid_idle: got %b want 0", mem_rd_en); else n_pass++;
      line = rand_line();
      ic_rd_req = 1'b1; ic_rd_addr = 32'h0000_5040;
      tick();
      n_checks++; if (mem_rd_en !== 1'b1 || mem_addr !== 32'h0000_5040) $display("FAIL rmid_after_strobe: got %b/%h want 1/00005040", mem_rd_en, mem_addr); else n_pass++;
      mem_rd_valid = 1'b1; mem_rd_line = line;
      tick();
      mem_rd_valid = 1'b0;
      n_checks++; if (ic_rd_valid !== 1'b1 || ic_rd_line !== line) $display("FAIL rmid_after_pulse: got %b/%h want 1/%h", ic_rd_valid, ic_rd_line, line); else n_pass++;
      ic_rd_req = 1'b0;
      tick();
   endtask

   initial begin
      test_reset();
      test_ic_fill();
      test_contention();
      test_write_priority();
      test_back_to_back();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
